// File: rtl/redmule_tile_sequencer.sv
// Tile sequencer for the RedMulE GEMM engine.
// Walks the row / column / depth tiling loop nest and issues one registered
// tile descriptor per valid/ready handshake, depth innermost, row outermost.
// Dimension slot 0 is depth, slot 1 is column, slot 2 is row throughout.
module redmule_tile_sequencer #(
  parameter int unsigned ARRAY_WIDTH  = 8,
  parameter int unsigned ARRAY_HEIGHT = 8,
  parameter int unsigned TILE_DEPTH   = 16,
  parameter int unsigned ITER_W       = 16,
  parameter int unsigned LFT_W        = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ITER_W-1:0] x_rows_iter_i,
  input  logic [ITER_W-1:0] w_cols_iter_i,
  input  logic [ITER_W-1:0] x_cols_iter_i,
  input  logic [LFT_W-1:0]  x_rows_lftovr_i,
  input  logic [LFT_W-1:0]  w_cols_lftovr_i,
  input  logic [LFT_W-1:0]  x_cols_lftovr_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [ITER_W-1:0] row_idx_o,
  output logic [ITER_W-1:0] col_idx_o,
  output logic [ITER_W-1:0] dep_idx_o,
  output logic [LFT_W-1:0]  row_len_o,
  output logic [LFT_W-1:0]  col_len_o,
  output logic [LFT_W-1:0]  dep_len_o,
  output logic              first_dep_o,
  output logic              last_dep_o,
  output logic              last_tile_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic              r_valid;
  logic              r_done;
  logic              r_first_dep;
  logic              r_last_dep;
  logic              r_last_tile;

  // Captured job configuration
  logic [ITER_W-1:0] r_iter [3];
  logic [LFT_W-1:0]  r_lft  [3];

  // Current descriptor indices and effective lengths
  logic [ITER_W-1:0] r_idx  [3];
  logic [LFT_W-1:0]  r_len  [3];

  logic [ITER_W-1:0] w_in_iter  [3];
  logic [LFT_W-1:0]  w_in_lft   [3];
  logic [ITER_W-1:0] w_sel_iter [3];
  logic [LFT_W-1:0]  w_sel_lft  [3];
  logic [ITER_W-1:0] w_nidx     [3];
  logic [LFT_W-1:0]  w_nlen     [3];
  logic [2:0]        w_at_max;
  logic [2:0]        w_nat_max;
  logic [2:0]        w_adv;
  logic              w_idle;
  logic              w_hs;
  logic              w_start;
  logic              w_all_nz;
  logic              w_load;
  logic              w_finish;

  assign w_in_iter[0] = x_cols_iter_i;
  assign w_in_iter[1] = w_cols_iter_i;
  assign w_in_iter[2] = x_rows_iter_i;
  assign w_in_lft[0]  = x_cols_lftovr_i;
  assign w_in_lft[1]  = w_cols_lftovr_i;
  assign w_in_lft[2]  = x_rows_lftovr_i;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_hs     = r_valid & tile_ready_i;
  assign w_start  = w_idle & start_i;
  assign w_all_nz = (x_rows_iter_i != '0) && (w_cols_iter_i != '0) && (x_cols_iter_i != '0);
  // A new descriptor is loaded on the first tile of a job or on every
  // accepted non-final tile; the final accepted tile ends the job.
  assign w_load   = (w_start & w_all_nz) | (w_hs & ~r_last_tile);
  assign w_finish = w_hs & r_last_tile;

  // Carry chain: depth advances on every handshake, outer dims on wrap
  assign w_adv[0] = w_hs;
  for (genvar gi = 1; gi < 3; gi++) begin : g_carry
    assign w_adv[gi] = w_adv[gi-1] & w_at_max[gi-1];
  end

  // Per-dimension next index and next effective length. In IDLE the first
  // tile is computed straight from the configuration inputs being captured.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dim
    localparam int unsigned FULL = (gi == 0) ? TILE_DEPTH :
                                   (gi == 1) ? ARRAY_HEIGHT : ARRAY_WIDTH;
    assign w_sel_iter[gi] = w_idle ? w_in_iter[gi] : r_iter[gi];
    assign w_sel_lft[gi]  = w_idle ? w_in_lft[gi]  : r_lft[gi];
    assign w_at_max[gi]   = (r_idx[gi] == r_iter[gi] - ITER_W'(1));
    assign w_nidx[gi]     = w_idle        ? '0 :
                            !w_adv[gi]    ? r_idx[gi] :
                            w_at_max[gi]  ? '0 : r_idx[gi] + ITER_W'(1);
    assign w_nat_max[gi]  = (w_nidx[gi] == w_sel_iter[gi] - ITER_W'(1));
    assign w_nlen[gi]     = (w_nat_max[gi] && (w_sel_lft[gi] != '0)) ?
                            w_sel_lft[gi] : LFT_W'(FULL);
  end

  // Control FSM: IDLE -> RUN/DONE on start, RUN -> DONE on last tile, DONE -> IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (w_all_nz) begin
              r_state <= ST_RUN;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_finish) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Configuration capture on an accepted start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 3; k++) begin
        r_iter[k] <= '0;
        r_lft[k]  <= '0;
      end
    end else if (clear_i) begin
      for (int k = 0; k < 3; k++) begin
        r_iter[k] <= '0;
        r_lft[k]  <= '0;
      end
    end else if (w_start) begin
      for (int k = 0; k < 3; k++) begin
        r_iter[k] <= w_in_iter[k];
        r_lft[k]  <= w_in_lft[k];
      end
    end
  end

  // Descriptor registers: loaded together so all fields share one latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 3; k++) begin
        r_idx[k] <= '0;
        r_len[k] <= '0;
      end
      r_first_dep <= 1'b0;
      r_last_dep  <= 1'b0;
      r_last_tile <= 1'b0;
    end else if (clear_i || w_finish) begin
      for (int k = 0; k < 3; k++) begin
        r_idx[k] <= '0;
        r_len[k] <= '0;
      end
      r_first_dep <= 1'b0;
      r_last_dep  <= 1'b0;
      r_last_tile <= 1'b0;
    end else if (w_load) begin
      for (int k = 0; k < 3; k++) begin
        r_idx[k] <= w_nidx[k];
        r_len[k] <= w_nlen[k];
      end
      r_first_dep <= (w_nidx[0] == '0);
      r_last_dep  <= w_nat_max[0];
      r_last_tile <= &w_nat_max;
    end
  end

  assign tile_valid_o = r_valid;
  assign dep_idx_o    = r_idx[0];
  assign col_idx_o    = r_idx[1];
  assign row_idx_o    = r_idx[2];
  assign dep_len_o    = r_len[0];
  assign col_len_o    = r_len[1];
  assign row_len_o    = r_len[2];
  assign first_dep_o  = r_first_dep;
  assign last_dep_o   = r_last_dep;
  assign last_tile_o  = r_last_tile;
  assign busy_o       = (r_state != ST_IDLE);
  assign done_o       = r_done;

endmodule
